// File: rtl/baslangic_getir_denetleyici.sv
// Instruction-fetch controller: routes core fetches to the boot ROM or main memory, returns one registered instruction.
// Latency: ROM accept->valid 2 cycles (1 per 3 back-to-back); memory = response cycles + 1, bounded by ZAMAN_ASIMI.
// Backpressure: getir_hazir_c low while a fetch is in flight; requests seen while not ready are ignored, not queued.
//
// Ports:
//   clk_g, rst_g                     clock, synchronous active-low reset
//   getir_istek_g/adres_g            core fetch request and byte address
//   getir_hazir_c                    controller idle (accept = istek && hazir)
//   getir_buyruk_c/gecerli_c         returned instruction (held) and its one-cycle valid pulse
//   rom_ena_c/adres_c, rom_buyruk_g  boot ROM enable, byte offset, data (one cycle after enable)
//   bellek_istek_c/adres_c           main-memory request level and byte address
//   bellek_buyruk_g/gecerli_g        main-memory data and single-cycle valid
//   baslangic_bitti_c, hata_c        sticky boot hand-off and memory-timeout flags
//
// Optional: define BASLANGIC_GERI_DONUS_EN to keep the ROM reachable after hand-off.
module baslangic_getir_denetleyici #(
  parameter logic [31:0] ROM_TABAN   = 32'h0000_0000,
  parameter int          ROM_KELIME  = 41,
  parameter int          ZAMAN_ASIMI = 255,
  parameter logic [31:0] NOP_BUYRUK  = 32'h0000_0013
) (
  input  logic        clk_g,
  input  logic        rst_g,
  input  logic        getir_istek_g,
  input  logic [31:0] getir_adres_g,
  output logic        getir_hazir_c,
  output logic [31:0] getir_buyruk_c,
  output logic        getir_gecerli_c,
  output logic        rom_ena_c,
  output logic [31:0] rom_adres_c,
  input  logic [31:0] rom_buyruk_g,
  output logic        bellek_istek_c,
  output logic [31:0] bellek_adres_c,
  input  logic [31:0] bellek_buyruk_g,
  input  logic        bellek_gecerli_g,
  output logic        baslangic_bitti_c,
  output logic        hata_c
);

  typedef enum logic [1:0] {
    BOSTA,
    ROM_OKU,
    BELLEK_BEKLE
  } durum_t;

  localparam logic [30:0] ROM_SINIR   = 31'(ROM_KELIME);
  localparam logic [16:0] ZAMAN_SINIR = 17'(ZAMAN_ASIMI);

  durum_t      durum;
  logic [15:0] sayac;
  logic [32:0] rom_fark;
  logic        rom_bolge;
  logic        rom_izinli;
  logic        kabul;

  // 33-bit difference: an address below ROM_TABAN borrows into bit 32 and
  // so compares as far outside the region. Byte-in-word bits are dropped.
  assign rom_fark  = {1'b0, getir_adres_g} - {1'b0, ROM_TABAN};
  assign rom_bolge = (rom_fark[32:2] < ROM_SINIR);

`ifdef BASLANGIC_GERI_DONUS_EN
  assign rom_izinli = 1'b1;
`else
  assign rom_izinli = ~baslangic_bitti_c;
`endif

  // The cycle carrying the valid pulse is still busy, which gives the
  // one-per-three-cycle ROM throughput.
  assign getir_hazir_c = rst_g && (durum == BOSTA) && !getir_gecerli_c;
  assign kabul         = getir_istek_g && getir_hazir_c;
  assign rom_ena_c     = kabul && rom_bolge && rom_izinli;
  assign rom_adres_c   = rom_fark[31:0];

  always_ff @(posedge clk_g) begin
    if (!rst_g) begin
      durum             <= BOSTA;
      getir_buyruk_c    <= 32'h0;
      getir_gecerli_c   <= 1'b0;
      bellek_istek_c    <= 1'b0;
      bellek_adres_c    <= 32'h0;
      baslangic_bitti_c <= 1'b0;
      hata_c            <= 1'b0;
      sayac             <= 16'h0;
    end else begin
      getir_gecerli_c <= 1'b0;
      case (durum)
        BOSTA: begin
          if (kabul) begin
            if (rom_bolge && rom_izinli) begin
              durum <= ROM_OKU;
            end else begin
              bellek_adres_c <= getir_adres_g;
              bellek_istek_c <= 1'b1;
              sayac          <= 16'h0;
              durum          <= BELLEK_BEKLE;
              // Only a genuinely out-of-ROM fetch marks the hand-off.
              if (!rom_bolge) baslangic_bitti_c <= 1'b1;
            end
          end
        end
        ROM_OKU: begin
          getir_buyruk_c  <= rom_buyruk_g;
          getir_gecerli_c <= 1'b1;
          durum           <= BOSTA;
        end
        BELLEK_BEKLE: begin
          // Valid is tested first so a response on the timeout cycle wins.
          if (bellek_gecerli_g) begin
            getir_buyruk_c  <= bellek_buyruk_g;
            getir_gecerli_c <= 1'b1;
            bellek_istek_c  <= 1'b0;
            durum           <= BOSTA;
          end else if (({1'b0, sayac} + 17'd1) >= ZAMAN_SINIR) begin
            getir_buyruk_c  <= NOP_BUYRUK;
            getir_gecerli_c <= 1'b1;
            bellek_istek_c  <= 1'b0;
            hata_c          <= 1'b1;
            durum           <= BOSTA;
          end else begin
            sayac <= sayac + 16'd1;
          end
        end
        default: durum <= BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_baslangic_getir_denetleyici.sv
// Self-checking bench for baslangic_getir_denetleyici.
// Drives directed and random fetches; each is checked against a transaction-level model.
// The ROM and memory responders live here; the memory answer delay is chosen per fetch.
module tb_baslangic_getir_denetleyici;

  localparam logic [31:0] TABAN  = 32'h0000_0100;
  localparam int          KELIME = 41;
  localparam int          ZA     = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          ASLA   = 1000;  // memory never answers

  logic        clk_g = 1'b0;
  logic        rst_g;
  logic        getir_istek_g;
  logic [31:0] getir_adres_g;
  logic        getir_hazir_c;
  logic [31:0] getir_buyruk_c;
  logic        getir_gecerli_c;
  logic        rom_ena_c;
  logic [31:0] rom_adres_c;
  logic [31:0] rom_buyruk_g;
  logic        bellek_istek_c;
  logic [31:0] bellek_adres_c;
  logic [31:0] bellek_buyruk_g;
  logic        bellek_gecerli_g;
  logic        baslangic_bitti_c;
  logic        hata_c;

  baslangic_getir_denetleyici #(
    .ROM_TABAN  (TABAN),
    .ROM_KELIME (KELIME),
    .ZAMAN_ASIMI(ZA),
    .NOP_BUYRUK (NOP)
  ) dut (
    .clk_g            (clk_g),
    .rst_g            (rst_g),
    .getir_istek_g    (getir_istek_g),
    .getir_adres_g    (getir_adres_g),
    .getir_hazir_c    (getir_hazir_c),
    .getir_buyruk_c   (getir_buyruk_c),
    .getir_gecerli_c  (getir_gecerli_c),
    .rom_ena_c        (rom_ena_c),
    .rom_adres_c      (rom_adres_c),
    .rom_buyruk_g     (rom_buyruk_g),
    .bellek_istek_c   (bellek_istek_c),
    .bellek_adres_c   (bellek_adres_c),
    .bellek_buyruk_g  (bellek_buyruk_g),
    .bellek_gecerli_g (bellek_gecerli_g),
    .baslangic_bitti_c(baslangic_bitti_c),
    .hata_c           (hata_c)
  );

  always #5 clk_g = ~clk_g;

  int   testler = 0;
  int   hatalar = 0;
  logic bitti_m = 1'b0;
  logic hata_m  = 1'b0;

  function automatic logic [31:0] rom_kelime(input logic [31:0] idx);
    return {16'hB007, idx[15:0]};
  endfunction

  function automatic logic bolgede(input logic [31:0] a);
    longint x;
    x = longint'(a);
    return (x >= longint'(TABAN)) && (x < longint'(TABAN) + 4 * KELIME);
  endfunction

  // Boot ROM: one-cycle registered read; garbage when not enabled.
  always @(posedge clk_g) begin
    if (rom_ena_c) rom_buyruk_g <= rom_kelime({2'b00, rom_adres_c[31:2]});
    else           rom_buyruk_g <= $urandom;
  end

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    testler++;
    if (gozlenen !== beklenen) begin
      hatalar++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", etiket, gozlenen, beklenen, $time);
    end
  endtask

  // One complete fetch. gec = cycle of the memory wait in which valid arrives.
  task automatic getir(input logic [31:0] a, input int gec, input logic [31:0] md);
    int          n, k, hi, gk, bek_hi;
    logic        rom_yol, gor;
    logic [31:0] alinan, bek_dat;
    n = 0;
    while (!getir_hazir_c && n < 50) begin
      @(negedge clk_g);
      n++;
    end
    kontrol("hazir_bekle", {31'b0, getir_hazir_c}, 32'd1);
`ifdef BASLANGIC_GERI_DONUS_EN
    rom_yol = bolgede(a);
`else
    rom_yol = bolgede(a) && !bitti_m;
`endif
    getir_istek_g = 1'b1;
    getir_adres_g = a;
    #1;
    kontrol("rom_ena", {31'b0, rom_ena_c}, {31'b0, rom_yol});
    if (rom_yol) kontrol("rom_adres", rom_adres_c, a - TABAN);
    @(posedge clk_g);
    #1;
    if (!bolgede(a)) bitti_m = 1'b1;
    getir_istek_g = 1'($urandom_range(0, 1));
    getir_adres_g = $urandom;
    if (rom_yol) begin
      @(negedge clk_g);
      kontrol("rom_c1_gecerli", {31'b0, getir_gecerli_c}, 32'd0);
      kontrol("rom_c1_bitti", {31'b0, baslangic_bitti_c}, {31'b0, bitti_m});
      getir_istek_g = 1'($urandom_range(0, 1));
      @(negedge clk_g);
      getir_istek_g = 1'b0;
      kontrol("rom_c2_gecerli", {31'b0, getir_gecerli_c}, 32'd1);
      kontrol("rom_c2_hazir", {31'b0, getir_hazir_c}, 32'd0);
      kontrol("rom_veri", getir_buyruk_c, rom_kelime((a - TABAN) >> 2));
    end else begin
      bek_hi  = (gec <= ZA) ? gec : ZA;
      bek_dat = (gec <= ZA) ? md : NOP;
      if (gec > ZA) hata_m = 1'b1;
      k = 1; hi = 0; gk = 0; gor = 1'b0; alinan = 32'h0;
      while (k < 40 && !gor) begin
        @(negedge clk_g);
        if (getir_gecerli_c) begin
          gor    = 1'b1;
          gk     = k;
          alinan = getir_buyruk_c;
        end
        if (bellek_istek_c) hi++;
        if (k == 1) begin
          kontrol("bellek_adres", bellek_adres_c, a);
          kontrol("bellek_bitti", {31'b0, baslangic_bitti_c}, {31'b0, bitti_m});
        end
        bellek_gecerli_g = !gor && (k == gec);
        bellek_buyruk_g  = bellek_gecerli_g ? md : $urandom;
        getir_istek_g    = gor ? 1'b0 : 1'($urandom_range(0, 1));
        k++;
      end
      bellek_gecerli_g = 1'b0;
      kontrol("bellek_istek_sure", hi, bek_hi);
      kontrol("bellek_gecerli_an", gk, bek_hi + 1);
      kontrol("bellek_veri", alinan, bek_dat);
    end
    @(negedge clk_g);
    kontrol("sonra_hazir", {31'b0, getir_hazir_c}, 32'd1);
    kontrol("sonra_gecerli", {31'b0, getir_gecerli_c}, 32'd0);
    kontrol("hata", {31'b0, hata_c}, {31'b0, hata_m});
  endtask

  function automatic logic [31:0] rastgele_adres();
    case ($urandom_range(0, 3))
      0:       return TABAN + 4 * $urandom_range(0, KELIME - 1) + $urandom_range(0, 3);
      1:       return TABAN + 4 * KELIME + $urandom_range(0, 7) - 4;
      2:       return TABAN - $urandom_range(1, 8);
      default: return $urandom;
    endcase
  endfunction

  task automatic rastgele_getir(input int adet);
    for (int i = 0; i < adet; i++) getir(rastgele_adres(), $urandom_range(1, ZA + 3), $urandom);
  endtask

  task automatic sifirla_kontrol();
    int darbe;
    n_wait_ready();
    getir_istek_g = 1'b1;
    getir_adres_g = 32'h0000_5000;
    @(posedge clk_g);
    #1;
    getir_istek_g = 1'b0;
    repeat (3) @(negedge clk_g);
    kontrol("rst_oncesi_istek", {31'b0, bellek_istek_c}, 32'd1);
    rst_g         = 1'b0;
    getir_istek_g = 1'b1;
    getir_adres_g = TABAN;
    @(negedge clk_g);
    kontrol("rst_bellek_istek", {31'b0, bellek_istek_c}, 32'd0);
    kontrol("rst_hazir", {31'b0, getir_hazir_c}, 32'd0);
    kontrol("rst_rom_ena", {31'b0, rom_ena_c}, 32'd0);
    kontrol("rst_bitti", {31'b0, baslangic_bitti_c}, 32'd0);
    kontrol("rst_hata", {31'b0, hata_c}, 32'd0);
    kontrol("rst_buyruk", getir_buyruk_c, 32'd0);
    kontrol("rst_bellek_adres", bellek_adres_c, 32'd0);
    getir_istek_g = 1'b0;
    rst_g         = 1'b1;
    bitti_m       = 1'b0;
    hata_m        = 1'b0;
    darbe         = 0;
    repeat (12) begin
      @(negedge clk_g);
      if (getir_gecerli_c) darbe++;
    end
    kontrol("rst_sonra_darbe", darbe, 0);
  endtask

  task automatic n_wait_ready();
    int n;
    n = 0;
    while (!getir_hazir_c && n < 50) begin
      @(negedge clk_g);
      n++;
    end
    kontrol("hazir_bekle_rst", {31'b0, getir_hazir_c}, 32'd1);
  endtask

  initial begin
    rst_g            = 1'b0;
    getir_istek_g    = 1'b0;
    getir_adres_g    = 32'h0;
    bellek_buyruk_g  = 32'h0;
    bellek_gecerli_g = 1'b0;
    repeat (2) @(posedge clk_g);
    @(negedge clk_g);
    kontrol("sifir_hazir", {31'b0, getir_hazir_c}, 32'd0);
    kontrol("sifir_gecerli", {31'b0, getir_gecerli_c}, 32'd0);
    kontrol("sifir_buyruk", getir_buyruk_c, 32'd0);
    kontrol("sifir_bellek_istek", {31'b0, bellek_istek_c}, 32'd0);
    kontrol("sifir_bellek_adres", bellek_adres_c, 32'd0);
    kontrol("sifir_bitti", {31'b0, baslangic_bitti_c}, 32'd0);
    kontrol("sifir_hata", {31'b0, hata_c}, 32'd0);
    rst_g = 1'b1;
    @(negedge clk_g);
    kontrol("sifir_sonra_hazir", {31'b0, getir_hazir_c}, 32'd1);

    getir(TABAN, 1, 32'h0);                 // first ROM word
    getir(32'h0000_01A0, 1, 32'h0);         // last ROM word
    getir(32'h0000_01A3, 1, 32'h0);         // byte bits ignored
    getir(32'h0000_01A4, 3, 32'h1111_2222); // just past ROM: hand-off
    getir(32'h0001_0000, 5, 32'hDEAD_BEEF); // 5-cycle memory answer
    getir(32'h0000_2000, ZA, 32'hCAFE_0001);// valid on the timeout cycle
    getir(TABAN, 2, 32'h3333_4444);         // in-ROM after hand-off
    getir(32'h0000_3000, ASLA, 32'h0);      // timeout -> NOP, hata
    getir(32'h0000_4000, 1, 32'h5555_6666); // hata stays set
    rastgele_getir(40);

    sifirla_kontrol();
    getir(TABAN + 4, 1, 32'h0);             // ROM reachable again
    getir(TABAN - 4, 4, 32'h7777_8888);     // below base -> memory
    rastgele_getir(20);

    $display("[TB] %0d tests run, %0d failed", testler, hatalar);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", testler, hatalar);
    $fatal(1, "watchdog");
  end

endmodule
